// File: rtl/ship_move_ctrl.sv
// Player ship horizontal movement with press-and-hold auto-repeat, clamped to
// the playfield, plus a req/ack fire request towards the missile unit.
module ship_move_ctrl #(
  parameter int W        = 10,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 600,
  parameter int X_INIT   = 300,
  parameter int STEP     = 4,
  parameter int REP_DLY  = 25000000,
  parameter int REP_RATE = 2500000,
  parameter int CW       = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         game_en,
  input  logic         left_clean,
  input  logic         left_single,
  input  logic         right_clean,
  input  logic         right_single,
  input  logic         fire_single,
  input  logic         fire_ack,
  input  logic         missile_busy,
  output logic [W-1:0] ship_x,
  output logic         fire_req,
  output logic [W-1:0] fire_x,
  output logic         step_evt
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  localparam logic [W:0]    X_MIN_E   = (W+1)'(X_MIN);
  localparam logic [W:0]    X_MAX_E   = (W+1)'(X_MAX);
  localparam logic [W:0]    STEP_E    = (W+1)'(STEP);
  localparam logic [W-1:0]  X_MIN_V   = W'(X_MIN);
  localparam logic [W-1:0]  X_MAX_V   = W'(X_MAX);
  localparam logic [W-1:0]  X_INIT_V  = W'(X_INIT);
  localparam logic [CW-1:0] DLY_LAST  = CW'(REP_DLY - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(REP_RATE - 1);

  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  ship_x_q, ship_x_d;
  logic          step_evt_q, step_evt_d;
  logic          fire_req_q, fire_req_d;
  logic [W-1:0]  fire_x_q, fire_x_d;

  logic          dir_left, dir_right, abort, do_step, step_right;
  logic [W:0]    x_ext, x_dec, x_inc;
  logic [W-1:0]  x_next;

  // dir_q: 1 = RIGHT, 0 = LEFT; only meaningful outside IDLE.
  assign dir_left  = left_clean & ~right_clean;
  assign dir_right = right_clean & ~left_clean;
  assign abort     = ~game_en | (dir_q ? ~dir_right : ~dir_left);

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    do_step    = 1'b0;
    step_right = dir_q;
    case (state_q)
      IDLE: begin
        if (game_en && left_single && dir_left) begin
          do_step    = 1'b1;
          step_right = 1'b0;
          dir_d      = 1'b0;
          cnt_d      = '0;
          state_d    = HOLD;
        end else if (game_en && right_single && dir_right) begin
          do_step    = 1'b1;
          step_right = 1'b1;
          dir_d      = 1'b1;
          cnt_d      = '0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == DLY_LAST) begin
          do_step = 1'b1;
          cnt_d   = '0;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == RATE_LAST) begin
          do_step = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // One extra bit: a LEFT step below zero shows up as a negative signed value.
  always_comb begin
    x_ext = {1'b0, ship_x_q};
    x_dec = x_ext - STEP_E;
    x_inc = x_ext + STEP_E;
    if (step_right) begin
      x_next = (x_inc > X_MAX_E) ? X_MAX_V : x_inc[W-1:0];
    end else begin
      x_next = ($signed(x_dec) < $signed(X_MIN_E)) ? X_MIN_V : x_dec[W-1:0];
    end
    ship_x_d   = ship_x_q;
    step_evt_d = 1'b0;
    if (do_step && (x_next != ship_x_q)) begin
      ship_x_d   = x_next;
      step_evt_d = 1'b1;
    end
  end

  // Fire presses arriving while a request is pending or a missile flies are dropped.
  always_comb begin
    fire_req_d = fire_req_q;
    fire_x_d   = fire_x_q;
    if (fire_req_q) begin
      if (fire_ack) fire_req_d = 1'b0;
    end else if (fire_single && game_en && !missile_busy) begin
      fire_req_d = 1'b1;
      fire_x_d   = ship_x_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      ship_x_q   <= X_INIT_V;
      step_evt_q <= 1'b0;
      fire_req_q <= 1'b0;
      fire_x_q   <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      ship_x_q   <= ship_x_d;
      step_evt_q <= step_evt_d;
      fire_req_q <= fire_req_d;
      fire_x_q   <= fire_x_d;
    end
  end

  assign ship_x   = ship_x_q;
  assign step_evt = step_evt_q;
  assign fire_req = fire_req_q;
  assign fire_x   = fire_x_q;

endmodule

// File: tb/tb_ship_move_ctrl.sv
// Directed bench for ship_move_ctrl: a cycle model pushes expected outputs to
// a queue per driven cycle; the negedge checker pops and compares them.
module tb_ship_move_ctrl;

  localparam int W        = 10;
  localparam int X_MIN    = 0;
  localparam int X_MAX    = 20;
  localparam int X_INIT   = 8;
  localparam int STEP     = 4;
  localparam int REP_DLY  = 8;
  localparam int REP_RATE = 4;
  localparam int CW       = 25;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         game_en = 1'b0;
  logic         lc = 1'b0, ls = 1'b0, rc = 1'b0, rs = 1'b0;
  logic         fs = 1'b0, ack = 1'b0, busy = 1'b0;
  logic [W-1:0] ship_x, fire_x;
  logic         fire_req, step_evt;

  ship_move_ctrl #(
    .W(W), .X_MIN(X_MIN), .X_MAX(X_MAX), .X_INIT(X_INIT), .STEP(STEP),
    .REP_DLY(REP_DLY), .REP_RATE(REP_RATE), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .game_en(game_en),
    .left_clean(lc), .left_single(ls), .right_clean(rc), .right_single(rs),
    .fire_single(fs), .fire_ack(ack), .missile_busy(busy),
    .ship_x(ship_x), .fire_req(fire_req), .fire_x(fire_x), .step_evt(step_evt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    bit evt;
    bit freq;
    int fx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   evt_cnt = 0;

  // Reference model state: hold counts cycles since the first step of a press.
  int m_x = X_INIT, m_hold = 0, m_fx = 0;
  bit m_act = 0, m_dir = 0, m_freq = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_push();
    bit dl, dr, stp;
    int nx;
    exp_t e;
    dl  = lc && !rc;
    dr  = rc && !lc;
    stp = 0;
    if (!m_act) begin
      if (game_en && ((ls && dl) || (rs && dr))) begin
        m_act = 1; m_dir = dr; m_hold = 0; stp = 1;
      end
    end else if (!game_en || (m_dir ? !dr : !dl)) begin
      m_act = 0;
    end else begin
      m_hold++;
      if (m_hold == REP_DLY || (m_hold > REP_DLY && (m_hold - REP_DLY) % REP_RATE == 0))
        stp = 1;
    end
    nx = m_x;
    if (stp) begin
      if (m_dir) nx = (m_x + STEP > X_MAX) ? X_MAX : m_x + STEP;
      else       nx = (m_x - STEP < X_MIN) ? X_MIN : m_x - STEP;
    end
    e.evt = (nx != m_x);
    if (m_freq) begin
      if (ack) m_freq = 0;
    end else if (fs && game_en && !busy) begin
      m_freq = 1; m_fx = m_x;
    end
    m_x    = nx;
    e.x    = m_x;
    e.freq = m_freq;
    e.fx   = m_fx;
    sb.push_back(e);
  endtask

  task automatic tick();
    model_push();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset: outputs are checked before any clock edge occurs.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ship_x",   32'(ship_x),   32'(X_INIT));
    chk("rst_fire_req", 32'(fire_req), 32'(0));
    chk("rst_fire_x",   32'(fire_x),   32'(0));
    chk("rst_step_evt", 32'(step_evt), 32'(0));
    m_x = X_INIT; m_hold = 0; m_fx = 0; m_act = 0; m_dir = 0; m_freq = 0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (step_evt === 1'b1) evt_cnt++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_ship_x",   32'(ship_x),   32'(e.x));
      chk("sb_step_evt", 32'(step_evt), 32'(e.evt));
      chk("sb_fire_req", 32'(fire_req), 32'(e.freq));
      chk("sb_fire_x",   32'(fire_x),   32'(e.fx));
    end
  end

  initial begin
    int base;
    game_en = 1'b1;
    @(negedge clk);
    #1;
    do_reset();

    // Tap RIGHT: clean high 3 cycles, one step 8->12
    base = evt_cnt;
    rc = 1; rs = 1; tick();
    chk("tap_r_x", 32'(ship_x), 32'd12);
    chk("tap_r_evt", 32'(step_evt), 32'd1);
    rs = 0; ticks(2);
    rc = 0; ticks(6);
    chk("tap_r_cnt", 32'(evt_cnt - base), 32'd1);
    chk("tap_r_hold_x", 32'(ship_x), 32'd12);

    // Hold LEFT 30 cycles from 8: 4, then 0 eight cycles later, then clamp
    do_reset();
    base = evt_cnt;
    lc = 1; ls = 1; tick();
    chk("hold_l_first", 32'(ship_x), 32'd4);
    ls = 0; ticks(7);
    chk("hold_l_before2", 32'(ship_x), 32'd4);
    tick();
    chk("hold_l_second", 32'(ship_x), 32'd0);
    ticks(21);
    lc = 0; ticks(3);
    chk("hold_l_cnt", 32'(evt_cnt - base), 32'd2);
    chk("hold_l_floor", 32'(ship_x), 32'd0);

    // Hold RIGHT: 12, 16, 20 then clamped; 3 pulses
    do_reset();
    base = evt_cnt;
    rc = 1; rs = 1; tick();
    rs = 0; ticks(8);
    chk("hold_r_16", 32'(ship_x), 32'd16);
    ticks(4);
    chk("hold_r_20", 32'(ship_x), 32'd20);
    ticks(10);
    chk("hold_r_cnt", 32'(evt_cnt - base), 32'd3);

    // Both pressed while in REPEAT: back to IDLE, no further steps
    base = evt_cnt;
    lc = 1; ticks(6);
    lc = 0; ticks(10);
    chk("both_no_step", 32'(evt_cnt - base), 32'd0);
    rc = 0; tick();
    lc = 1; ls = 1; tick();
    chk("tap_l_x", 32'(ship_x), 32'd16);
    ls = 0; ticks(2);
    lc = 0; ticks(10);
    chk("tap_l_cnt", 32'(evt_cnt - base), 32'd1);

    // Fire with a same-cycle step: fire_x is the pre-step position
    do_reset();
    fs = 1; rc = 1; rs = 1; tick();
    chk("fire_req_up", 32'(fire_req), 32'd1);
    chk("fire_x_pre", 32'(fire_x), 32'd8);
    fs = 0; rs = 0; rc = 0; ticks(2);
    fs = 1; tick();
    fs = 0; tick();
    ack = 1; tick();
    ack = 0;
    chk("fire_req_drop", 32'(fire_req), 32'd0);
    ack = 1; ticks(2);
    ack = 0; tick();
    chk("ack_ignored", 32'(fire_req), 32'd0);
    fs = 1; tick();
    fs = 0;
    chk("fire2_x", 32'(fire_x), 32'd12);
    ack = 1; tick();
    ack = 0; tick();

    // game_en low: no step, no new request, outstanding request held
    do_reset();
    game_en = 0;
    rc = 1; rs = 1; fs = 1; tick();
    rs = 0; fs = 0; rc = 0; ticks(2);
    chk("dis_x", 32'(ship_x), 32'd8);
    chk("dis_req", 32'(fire_req), 32'd0);
    game_en = 1; fs = 1; tick();
    fs = 0; game_en = 0; ticks(3);
    chk("dis_req_held", 32'(fire_req), 32'd1);
    ack = 1; tick();
    ack = 0; game_en = 1; tick();

    // Reset mid-REPEAT with a request pending
    do_reset();
    rc = 1; rs = 1; tick();
    rs = 0; ticks(10);
    fs = 1; tick();
    fs = 0; ticks(2);
    chk("pre_rst_req", 32'(fire_req), 32'd1);
    do_reset();
    base = evt_cnt;
    ticks(12);
    chk("post_rst_no_step", 32'(evt_cnt - base), 32'd0);
    chk("post_rst_x", 32'(ship_x), 32'd8);
    rc = 0;
    busy = 1; fs = 1; tick();
    fs = 0; tick();
    chk("busy_no_req", 32'(fire_req), 32'd0);
    busy = 0; ticks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ship_move_ctrl.md
Name: ship_move_ctrl

Overview:
- Consumes the clean (level) and single (one-cycle pulse) outputs of the per-button debouncers for LEFT, RIGHT and FIRE.
- Produces the player ship's horizontal position with press-and-hold auto-repeat, clamped to the playfield.
- Issues fire requests to the missile unit over a req/ack handshake.
- Sits between the button debouncers and the game-logic/VGA rendering path.

Parameters:
- W, 10, width of the position bus.
- X_MIN, 0, leftmost legal ship_x.
- X_MAX, 600, rightmost legal ship_x.
- X_INIT, 300, ship_x after reset; must satisfy X_MIN <= X_INIT <= X_MAX.
- STEP, 4, pixels moved per step.
- REP_DLY, 25000000, cycles of continuous hold after the first step before auto-repeat starts.
- REP_RATE, 2500000, cycles between auto-repeat steps.
- CW, 25, width of the repeat counter; must hold max(REP_DLY, REP_RATE).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-high.
- game_en  in  1  1 = movement and fire are allowed.
- left_clean  in  1  debounced LEFT level.
- left_single  in  1  LEFT press pulse.
- right_clean  in  1  debounced RIGHT level.
- right_single  in  1  RIGHT press pulse.
- fire_single  in  1  FIRE press pulse.
- fire_ack  in  1  missile unit accepts the request.
- missile_busy  in  1  a missile is already in flight.
- ship_x  out  W  current ship position.
- fire_req  out  1  fire request, held until acknowledged.
- fire_x  out  W  ship_x captured at request time.
- step_evt  out  1  one-cycle pulse on each cycle in which ship_x changes.

Behaviour:
- Reset (asynchronous, active-high) values: ship_x=X_INIT, fire_req=0, fire_x=0, step_evt=0, move FSM=IDLE, repeat counter=0.
- Direction decode:
  - dir=LEFT when left_clean & !right_clean.
  - dir=RIGHT when right_clean & !left_clean.
  - Otherwise dir=NONE.
  - A single pulse counts only if its own clean is high and the opposite clean is low.
- Move FSM states: IDLE, HOLD, REPEAT. All transitions are registered.
  - IDLE: on a valid left_single or right_single with game_en=1:
    - take one step in that direction in the next cycle (ship_x updates and step_evt=1 exactly one cycle after the pulse);
    - cnt<=0;
    - go to HOLD.
  - HOLD: cnt increments each cycle.
    - dir==NONE, or dir differs from the latched direction, or game_en=0: go to IDLE.
    - cnt==REP_DLY-1: one step, cnt<=0, go to REPEAT.
  - REPEAT: cnt increments each cycle.
    - dir==NONE, or dir differs from the latched direction, or game_en=0: go to IDLE.
    - cnt==REP_RATE-1: one step, cnt<=0, stay in REPEAT.
  - Direction change: release is required. Holding LEFT and then also pressing RIGHT gives dir=NONE, and the FSM returns to IDLE.
- Step arithmetic:
  - Compute in W+1 bits.
  - LEFT: ship_x <= max(ship_x-STEP, X_MIN). Underflow is detected through the extra bit, so there is no wrap.
  - RIGHT: ship_x <= min(ship_x+STEP, X_MAX).
  - step_evt=1 only if the value actually changes. At a bound, ship_x holds, step_evt=0, and the FSM still advances normally.
- Fire handshake:
  - Request: when fire_single=1, game_en=1, missile_busy=0 and fire_req=0 → next cycle fire_req=1 and fire_x=ship_x (value before any same-cycle step).
  - fire_req stays high until a cycle with fire_ack=1. It drops in the next cycle.
  - fire_x is stable while fire_req=1.
  - fire_single while fire_req=1 or missile_busy=1 is dropped, not queued.
  - fire_ack with fire_req=0 is ignored.
- game_en=0:
  - No new steps or requests start.
  - An outstanding fire_req is still held until fire_ack.
  - ship_x holds.
- Movement and fire are independent. A step and a fire request may occur in the same cycle.
- Reset mid-operation: all state returns to reset values immediately; a pending fire_req is abandoned.

Test Plan:
(All scenarios use X_MIN=0, X_MAX=20, X_INIT=8, STEP=4, REP_DLY=8, REP_RATE=4.)
- Tap RIGHT (single pulse with clean high for 3 cycles) → ship_x 8→12 one cycle after the pulse, one step_evt, FSM returns to IDLE, no further steps.
- Hold LEFT for 30 cycles → first step to 4, second step (to 0) 8 cycles later. Further repeat points hold ship_x=0 with step_evt=0, no wrap. Release → IDLE.
- Hold RIGHT from X_INIT → steps to 12, then 16 and 20 at 4-cycle intervals, then held at 20. Verify step_evt timing and count (3 pulses total).
- While holding RIGHT in REPEAT, assert left_clean → no further steps, FSM returns to IDLE. Release both, then tap LEFT → single step.
- fire_single with missile_busy=0 → fire_req=1 and fire_x=8 next cycle, held 5 cycles until fire_ack. A second fire_single during this window is dropped; fire_req drops the cycle after ack.
- Assert rst mid-REPEAT with fire_req pending → ship_x=8, fire_req=0 asynchronously. After release, no steps occur without a new press. fire_single with missile_busy=1 produces no request.
